// File: rtl/reveal_scheduler.sv
// Reveal scheduler: sequences every board-RAM access for one cell reveal.
// Zero-adjacency cells start an iterative flood fill driven by an internal index stack.
// Also keeps the safe-cell reveal count and the sticky endgame/win flags.
module reveal_scheduler #(
    parameter int unsigned COLS    = 8,
    parameter int unsigned ROWS    = 8,
    parameter int unsigned MINES   = 10,
    parameter int unsigned COUNT_W = 6,
    localparam int unsigned N      = COLS * ROWS,
    localparam int unsigned AW     = $clog2(N),
    localparam int unsigned XW     = $clog2(COLS),
    localparam int unsigned YW     = $clog2(ROWS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [XW-1:0]      req_x,
    input  logic [YW-1:0]      req_y,
    output logic [AW-1:0]      mem_addr,
    output logic               mem_rd_en,
    input  logic [5:0]         mem_rdata,
    output logic               mem_we,
    output logic [5:0]         mem_wdata,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] reveal_count,
    output logic               endgame,
    output logic               win
);

    localparam logic [COUNT_W-1:0] WIN_COUNT = COUNT_W'(N - MINES);

    typedef enum logic [2:0] {
        StIdle,
        StRd0,
        StEv0,
        StPop,
        StNrd,
        StNev,
        StFin
    } state_t;

    state_t             state;
    logic [AW-1:0]      cell_addr;
    logic [XW-1:0]      centre_x;
    logic [YW-1:0]      centre_y;
    logic [3:0]         k;
    logic [AW:0]        sp;
    logic [AW-1:0]      stack [N];

    logic [AW-1:0]      top_idx;
    logic [AW-1:0]      nb_addr;
    logic               nb_on;
    logic [COUNT_W-1:0] count_inc;
    logic               rd_mine;
    logic               rd_revealed;
    logic               rd_zero;
    int                 dx;
    int                 dy;
    int                 nx;
    int                 ny;

    assign top_idx     = AW'(sp - 1'b1);
    assign rd_mine     = mem_rdata[5];
    assign rd_revealed = mem_rdata[4];
    assign rd_zero     = (mem_rdata[3:0] == 4'd0);
    assign count_inc   = (reveal_count == '1) ? reveal_count : reveal_count + 1'b1;

    // Neighbour k of the current centre, in NW,N,NE,W,E,SW,S,SE order; no wrap at edges.
    always_comb begin
        dx = 0;
        dy = 0;
        case (k[2:0])
            3'd0: begin dx = -1; dy = -1; end
            3'd1: begin dx = 0;  dy = -1; end
            3'd2: begin dx = 1;  dy = -1; end
            3'd3: begin dx = -1; dy = 0;  end
            3'd4: begin dx = 1;  dy = 0;  end
            3'd5: begin dx = -1; dy = 1;  end
            3'd6: begin dx = 0;  dy = 1;  end
            default: begin dx = 1; dy = 1; end
        endcase
        nx      = int'(centre_x) + dx;
        ny      = int'(centre_y) + dy;
        nb_on   = (k < 4'd8) && (nx >= 0) && (nx < int'(COLS)) && (ny >= 0) && (ny < int'(ROWS));
        nb_addr = AW'(ny * int'(COLS) + nx);
    end

    // RAM address and strobes decoded from the current state.
    always_comb begin
        mem_addr  = '0;
        mem_rd_en = 1'b0;
        mem_we    = 1'b0;
        unique case (state)
            StRd0: begin
                mem_addr  = cell_addr;
                mem_rd_en = 1'b1;
            end
            StEv0: begin
                mem_addr = cell_addr;
                mem_we   = !rd_revealed;
            end
            StNrd: begin
                mem_addr  = nb_addr;
                mem_rd_en = nb_on;
            end
            StNev: begin
                mem_addr = nb_addr;
                mem_we   = !rd_revealed && !rd_mine;
            end
            default: begin
                mem_addr = '0;
            end
        endcase
    end

    // Status outputs; the write word is the cell just read with its revealed bit set.
    always_comb begin
        mem_wdata = {mem_rdata[5], 1'b1, mem_rdata[3:0]};
        busy      = (state != StIdle);
        done      = (state == StFin);
        req_ready = (state == StIdle) && !endgame;
    end

    // Main sequencer: request intake, evaluation, flood-fill stack walk and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StIdle;
            cell_addr    <= '0;
            centre_x     <= '0;
            centre_y     <= '0;
            k            <= '0;
            sp           <= '0;
            reveal_count <= '0;
            endgame      <= 1'b0;
            win          <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (req_valid && req_ready) begin
                        cell_addr <= AW'(32'(req_y) * COLS + 32'(req_x));
                        state     <= StRd0;
                    end
                end
                StRd0: begin
                    state <= StEv0;
                end
                StEv0: begin
                    if (rd_revealed) begin
                        state <= StFin;
                    end else if (rd_mine) begin
                        endgame <= 1'b1;
                        state   <= StFin;
                    end else begin
                        reveal_count <= count_inc;
                        if (rd_zero) begin
                            stack[sp[AW-1:0]] <= cell_addr;
                            sp                <= sp + 1'b1;
                            state             <= StPop;
                        end else begin
                            state <= StFin;
                        end
                    end
                end
                StPop: begin
                    if (sp == '0) begin
                        state <= StFin;
                    end else begin
                        sp       <= sp - 1'b1;
                        centre_x <= XW'(32'(stack[top_idx]) % COLS);
                        centre_y <= YW'(32'(stack[top_idx]) / COLS);
                        k        <= '0;
                        state    <= StNrd;
                    end
                end
                StNrd: begin
                    if (k == 4'd8) begin
                        state <= StPop;
                    end else if (!nb_on) begin
                        k <= k + 1'b1;
                    end else begin
                        state <= StNev;
                    end
                end
                StNev: begin
                    // Marking at push time keeps every cell on the stack at most once.
                    if (!rd_revealed && !rd_mine) begin
                        reveal_count <= count_inc;
                        if (rd_zero) begin
                            stack[sp[AW-1:0]] <= nb_addr;
                            sp                <= sp + 1'b1;
                        end
                    end
                    k     <= k + 1'b1;
                    state <= StNrd;
                end
                StFin: begin
                    if (reveal_count == WIN_COUNT) begin
                        endgame <= 1'b1;
                        win     <= 1'b1;
                    end
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
